pipe_stage_reg: RTL

//  Generic, width-parametrised pipeline stage register for the pipelined CPU.
//  It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches with one block.

---
 rtl/pipe_stage_reg_if.sv | 12 +
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream interface carrying one WIDTH-bit pipeline payload.
// The master drives valid/data and the slave drives ready.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake, a two-entry
// skid buffer for stall back-pressure, and a flush that injects a bubble.
// Optional stall-cycle counter: define PIPE_STAGE_STALL_CNT_EN to build it;
// otherwise o_stall_cnt is tied to zero.
//
//  state    | meaning
//  ---------+---------------------------------------------
//  ST_EMPTY | main register invalid, nothing held
//  ST_ONE   | main register valid, skid register empty
//  ST_FULL  | main and skid both valid, upstream stalled
module pipe_stage_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    pipe_stage_reg_if.slave      s_in,
    pipe_stage_reg_if.master     m_out,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // in_ready depends only on skid occupancy and reset, never on out_ready,
    // so no combinational path runs from downstream ready to upstream ready.
    assign w_in_ready  = (r_state != ST_FULL) & ~i_reset;
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = s_in.valid & w_in_ready;
    assign w_out_fire  = w_out_valid & m_out.ready;

    assign s_in.ready  = w_in_ready;
    assign m_out.valid = w_out_valid;
    assign m_out.data  = r_main;

    // Next-state and register-load decode for the handshake FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State and payload registers; reset wins over flush, flush over handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= s_in.data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= s_in.data;
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating count of cycles where a live payload waits on downstream;
    // only reset clears it so stalls across a squash are still accounted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !m_out.ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule
